// File: rtl/conv_cfg_sched_if.sv
// Host configuration port for conv_cfg_sched:
// valid/ready write channel plus a commit strobe.
interface conv_cfg_sched_if #(
    parameter int C_W = 8
);
    logic           i_cfg_valid;
    logic           o_cfg_ready;
    logic [2:0]     i_cfg_addr;
    logic [C_W+1:0] i_cfg_data;
    logic           i_cfg_commit;

    modport master (
        output i_cfg_valid,
        output i_cfg_addr,
        output i_cfg_data,
        output i_cfg_commit,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_addr,
        input  i_cfg_data,
        input  i_cfg_commit,
        output o_cfg_ready
    );
endinterface

// File: rtl/conv_cfg_sched.sv
// Frame-synchronous threshold scheduler for conv: shadow bank copied to active at frame start.
// Optional CFG_AUTO_WB_EN adds per-frame auto adjustment of the WB threshold.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif

module conv_cfg_sched #(
    parameter int             C_W          = `COLOR_WIDTH,
    parameter logic [C_W+1:0] RGB_ERR_DEF  = 'd24,
    parameter logic [C_W+1:0] RGB_VMIN_DEF = 'd16,
    parameter logic [C_W+1:0] RGB_VMAX_DEF = 'd255,
    parameter logic [C_W+1:0] YEL_ERR_DEF  = 'd24,
    parameter logic [C_W+1:0] YEL_VMIN_DEF = 'd16,
    parameter logic [C_W+1:0] YEL_VMAX_DEF = 'd255,
    parameter logic [C_W+1:0] WB_THR_DEF   = 'd96,
    parameter logic [19:0]    WB_CNT_HI    = 20'd200000,
    parameter logic [19:0]    WB_CNT_LO    = 20'd50000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                i_post_camvs,
    conv_cfg_sched_if.slave     cfg,
    input  logic                i_valid,
    input  logic [15:0]         i_data,
    output logic [C_W+1:0]      o_RGB_err,
    output logic [C_W+1:0]      o_RGB_Vmin,
    output logic [C_W+1:0]      o_RGB_Vmax,
    output logic [C_W+1:0]      o_YELLOW_err,
    output logic [C_W+1:0]      o_YELLOW_Vmin,
    output logic [C_W+1:0]      o_YELLOW_Vmax,
    output logic [C_W+1:0]      o_WB_threshold,
    output logic                o_pending,
    output logic                o_applied,
    output logic                o_cfg_err,
    output logic [15:0]         o_frame_cnt
);

    localparam logic [C_W+1:0] DEFS [7] = '{
        RGB_ERR_DEF, RGB_VMIN_DEF, RGB_VMAX_DEF,
        YEL_ERR_DEF, YEL_VMIN_DEF, YEL_VMAX_DEF,
        WB_THR_DEF
    };

    typedef enum logic [1:0] {
        IDLE,
        DIRTY,
        ARMED,
        APPLY
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           camvs_d;
    logic           fs;
    logic           accept;
    logic           wr_en;
    logic [C_W+1:0] shadow [7];
    logic [C_W+1:0] active [7];

    assign fs     = i_post_camvs & ~camvs_d;
    assign accept = cfg.i_cfg_valid & cfg.o_cfg_ready;
    assign wr_en  = accept & (cfg.i_cfg_addr != 3'd7);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            camvs_d     <= 1'b0;
            o_frame_cnt <= 16'd0;
            o_cfg_err   <= 1'b0;
            state       <= IDLE;
        end else begin
            camvs_d     <= i_post_camvs;
            o_cfg_err   <= accept & (cfg.i_cfg_addr == 3'd7);
            state       <= state_nx;
            if (fs)
                o_frame_cnt <= o_frame_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nx        = state;
        cfg.o_cfg_ready = 1'b0;
        o_pending       = 1'b0;
        o_applied       = 1'b0;
        unique case (state)
            IDLE: begin
                cfg.o_cfg_ready = 1'b1;
                if (cfg.i_cfg_commit)
                    state_nx = ARMED;
                else if (wr_en)
                    state_nx = DIRTY;
            end
            DIRTY: begin
                cfg.o_cfg_ready = 1'b1;
                o_pending       = 1'b1;
                if (cfg.i_cfg_commit)
                    state_nx = ARMED;
            end
            ARMED: begin
                o_pending = 1'b1;
                if (fs)
                    state_nx = APPLY;
            end
            APPLY: begin
                o_applied = 1'b1;
                state_nx  = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 7; i++)
                shadow[i] <= DEFS[i];
        end else if (wr_en) begin
            shadow[cfg.i_cfg_addr] <= cfg.i_cfg_data;
        end
    end

`ifdef CFG_AUTO_WB_EN
    logic [C_W+1:0] pix_sum;
    logic [19:0]    wb_cnt;

    // Luma-like brightness: R and B scaled to G's 6-bit range.
    assign pix_sum = {{(C_W-4){1'b0}}, i_data[15:11], 1'b0}
                   + {{(C_W-4){1'b0}}, i_data[10:5]}
                   + {{(C_W-4){1'b0}}, i_data[4:0], 1'b0};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            wb_cnt <= 20'd0;
        else if (fs || state == APPLY)
            wb_cnt <= 20'd0;
        else if (i_valid && pix_sum > active[6] && wb_cnt != 20'hFFFFF)
            wb_cnt <= wb_cnt + 20'd1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 7; i++)
                active[i] <= DEFS[i];
        end else if (state == APPLY) begin
            for (int i = 0; i < 7; i++)
                active[i] <= shadow[i];
        end else if (fs) begin
            if (wb_cnt > WB_CNT_HI && !(&active[6]))
                active[6] <= active[6] + 1'b1;
            else if (wb_cnt < WB_CNT_LO && active[6] != '0)
                active[6] <= active[6] - 1'b1;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{i_valid, i_data, WB_CNT_HI, WB_CNT_LO};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 7; i++)
                active[i] <= DEFS[i];
        end else if (state == APPLY) begin
            for (int i = 0; i < 7; i++)
                active[i] <= shadow[i];
        end
    end
`endif

    assign o_RGB_err      = active[0];
    assign o_RGB_Vmin     = active[1];
    assign o_RGB_Vmax     = active[2];
    assign o_YELLOW_err   = active[3];
    assign o_YELLOW_Vmin  = active[4];
    assign o_YELLOW_Vmax  = active[5];
    assign o_WB_threshold = active[6];

endmodule
